// File: rtl/maze_irs_link.sv
// Pipelined inter-router link: DEPTH skid-buffered stages between two mesh nodes,
// flushed while the destination is power-gated. Define IRS_LINK_STAT_EN for drop_cnt/occ.
module maze_irs_link #(
   parameter int DEPTH  = 2,
   parameter int ID_W   = 6,
   parameter int QOS_W  = 1,
   parameter int TYPE_W = 2,
   parameter int DATA_W = 64,
   parameter logic [ID_W-1:0] DST_ID = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pg_en,
   input  logic [ID_W-1:0]   pg_node,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [QOS_W-1:0]  in_qos,
   input  logic [TYPE_W-1:0] in_type,
   input  logic [ID_W-1:0]   in_src,
   input  logic [ID_W-1:0]   in_tgt,
   input  logic [DATA_W-1:0] in_data,
`ifdef IRS_LINK_STAT_EN
   output logic [15:0]       drop_cnt,
   output logic [3:0]        occ,
`endif
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [QOS_W-1:0]  out_qos,
   output logic [TYPE_W-1:0] out_type,
   output logic [ID_W-1:0]   out_src,
   output logic [ID_W-1:0]   out_tgt,
   output logic [DATA_W-1:0] out_data
);
   localparam int FW = QOS_W + TYPE_W + 2*ID_W + DATA_W;

   if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("maze_irs_link: DEPTH must be in 1..8");
   end

   logic          gated;
   logic [FW-1:0] in_flit;
   logic          stg_vld  [DEPTH];
   logic          stg_rdy  [DEPTH];
   logic [FW-1:0] stg_flit [DEPTH];

   assign gated   = pg_en && (pg_node == DST_ID);
   assign in_flit = {in_qos, in_type, in_src, in_tgt, in_data};

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic          up_vld, dn_rdy, push, pop;
      logic [FW-1:0] up_flit;
      logic          main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q;
      logic [FW-1:0] main_q, main_d, skid_q, skid_d;

      if (gi == 0) begin : g_head
         assign up_vld  = in_vld;
         assign up_flit = in_flit;
      end else begin : g_body
         assign up_vld  = stg_vld[gi-1];
         assign up_flit = stg_flit[gi-1];
      end
      if (gi == DEPTH-1) begin : g_tail
         assign dn_rdy = out_rdy;
      end else begin : g_inner
         assign dn_rdy = stg_rdy[gi+1];
      end

      assign push = up_vld && rdy_q;
      assign pop  = main_vld_q && dn_rdy;

      always_comb begin
         main_vld_d = main_vld_q;
         skid_vld_d = skid_vld_q;
         main_d     = main_q;
         skid_d     = skid_q;
         if (gated) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
         end else if (!main_vld_q || pop) begin
            if (skid_vld_q) begin
               main_d     = skid_q;
               main_vld_d = 1'b1;
               skid_vld_d = push;
               if (push) skid_d = up_flit;
            end else begin
               main_vld_d = push;
               if (push) main_d = up_flit;
            end
         end else if (push) begin
            skid_vld_d = 1'b1;
            skid_d     = up_flit;
         end
      end

      // rdy tracks the skid occupancy being written, so a full skid is never overrun
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
         end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= !skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
         end
      end

      assign stg_vld[gi]  = main_vld_q;
      assign stg_rdy[gi]  = rdy_q;
      assign stg_flit[gi] = main_q;
   end

   assign out_vld = stg_vld[DEPTH-1] && !gated;
   assign in_rdy  = stg_rdy[0] || gated;
   assign {out_qos, out_type, out_src, out_tgt, out_data} = stg_flit[DEPTH-1];

`ifdef IRS_LINK_STAT_EN
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] drop_q, drop_d;
   logic [16:0] drop_sum;

   assign drop_sum = {1'b0, drop_q} + 17'(cnt_q) + 17'(in_vld);

   always_comb begin
      cnt_d  = cnt_q + 5'(in_vld && stg_rdy[0]) - 5'(stg_vld[DEPTH-1] && out_rdy);
      drop_d = drop_q;
      if (gated) begin
         cnt_d  = '0;
         drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         drop_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
      end
   end

   // DEPTH=8 can hold 16 flits; the 4-bit view pins at 15
   assign occ      = (cnt_q > 5'd15) ? 4'hF : cnt_q[3:0];
   assign drop_cnt = drop_q;
`endif
endmodule
